pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. Operands of WIDTH bits are split into WIDTH/GROUP lookahead groups. Each group is resolved in its own pipeline stage, with the group carry registered between stages. A valid/ready handshake on both sides lets the block sit in streaming datapaths with backpressure. It is the multi-bit, multi-cycle generalisation of the team's 4-bit lookahead adder cell, adding carry-in, subtract mode, signed overflow and flow control.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP.
- GROUP, 4, bits resolved per lookahead group; 1..8.
- L (localparam) = WIDTH/GROUP, number of pipeline stages.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input on this edge.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  1 = A−B (B inverted, carry-in forced 1).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- out_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Accept: the input is accepted when in_valid & in_ready is high at a rising edge.
- Preprocessing on accept: b' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
- Stage registers R0..R(L−1), each holding:
  - a valid bit
  - the remaining operand bits
  - the sum bits computed so far
  - the pending group carry
  - the MSB carry-in (needed for ovf)
- Group k (bits k·GROUP .. k·GROUP+GROUP−1) computes P=a^b and G=a&b per bit. Its lookahead carries are c(i+1)=G(i)|P(i)&c(i), flattened within the group, and sum(i)=P(i)^c(i).
- Group 0 is computed combinationally from the inputs and written into R0 on accept. Group k is computed from R(k−1) and written into R(k).
- R(L−1) is the output register and drives out_sum, out_cout and out_ovf.
- Flow control, with no bubbles held when downstream is free:
  - adv(L−1) = ~v(L−1) | out_ready
  - adv(k) = ~v(k) | adv(k+1)
  - in_ready = adv(0)
- When adv(k) is high, R(k) loads from the previous stage. Its valid bit becomes the previous stage's valid, or in_valid for R0.
- When adv(k) is low, R(k) holds all contents.
- out_valid = v(L−1). The out_* fields are stable while out_valid & ~out_ready.
- Ordering: strictly FIFO; no transaction is dropped or duplicated.
- Arithmetic is modulo 2^WIDTH. out_cout and out_ovf are computed only at the MSB group.

## Timing
- Reset (rst_n low, asynchronous): all valid bits clear immediately, so out_valid=0. out_sum=0, out_cout=0, out_ovf=0, and all internal data registers are 0.
- in_ready is 1 from the first edge after reset release. It is combinational from the valid bits and out_ready (a ready chain; no register).
- Reset mid-operation: all in-flight transactions are discarded. There is no output pulse on release.
- Latency: a transaction accepted at edge t appears on out_valid after edge t+L−1, i.e. L register stages including the accepting edge.
  - L=1 means the result is visible immediately after the accepting edge.
- Throughput: one transaction per clock while out_ready=1.
- Full pipeline: in_ready=0 only when all L valid bits are set and out_ready=0. Capacity is L transactions.
- Simultaneous events: on the edge where the output is consumed, the pipeline shifts, and a new input is accepted on that same edge.

## Test plan
- WIDTH=16, GROUP=4, out_ready=1: 0xFFFF+0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. out_valid rises after the 4th edge counting the accept edge, for one cycle.
- Subtract: 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1. Also 0x0003−0x0005 → sum=0xFFFE, cout=0, ovf=0.
- Add overflow with carry-in: 0x7FFE+0x0000, cin=1 → 0x7FFF, ovf=0. Then 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1.
- Backpressure: stream 8 back-to-back operations (i+i·0x1111, i=0..7) and hold out_ready=0 for cycles 5..9.
  - in_ready falls once 4 transactions are buffered.
  - Outputs stay stable while stalled.
  - All 8 results arrive in order with no loss.
- Reset mid-stream: assert rst_n=0 asynchronously, between edges, with 3 operations in flight.
  - out_valid and out_sum drop to 0 without waiting for a clock edge.
  - After release, the first new operation 0x1234+0x4321 → 0x5555 after 4 edges, and no stale output appears.
- WIDTH=8, GROUP=8 (L=1): 0xAA+0x55, cin=1 → sum=0x00, cout=1, ovf=0, visible right after the accept edge.

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// Streaming handshake bundle for the pipelined carry-lookahead adder.
// The master drives operands and out_ready. The slave (the adder) drives
// in_ready and the result fields.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One GROUP-bit lookahead group is resolved per stage, and the group carry
// is registered between stages. Flow control is a combinational ready chain,
// so a free downstream never leaves bubbles in the pipe.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int L = WIDTH / GROUP;

    // Stage registers R0..R(L-1); R(L-1) is the output register
    logic [L-1:0]     r_vld;
    logic [WIDTH-1:0] r_a   [L];
    logic [WIDTH-1:0] r_b   [L];
    logic [WIDTH-1:0] r_sum [L];
    logic [L-1:0]     r_c;
    logic [L-1:0]     r_cmsb;

    // Next-state values each stage loads when it advances
    logic [WIDTH-1:0] w_b_pre;
    logic             w_c0;
    logic [L-1:0]     w_adv;
    logic [L-1:0]     w_nxt_vld;
    logic [WIDTH-1:0] w_nxt_a   [L];
    logic [WIDTH-1:0] w_nxt_b   [L];
    logic [WIDTH-1:0] w_nxt_sum [L];
    logic [L-1:0]     w_nxt_c;
    logic [L-1:0]     w_nxt_cmsb;
    logic [GROUP+1:0] w_res;

    // One lookahead group. Returns {carry out, carry into group MSB, sum bits}.
    function automatic logic [GROUP+1:0] cla_group(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             cin
    );
        logic [GROUP:0]   c;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] s;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            p[i]     = a[i] ^ b[i];
            g[i]     = a[i] & b[i];
            c[i + 1] = g[i] | (p[i] & c[i]);
            s[i]     = p[i] ^ c[i];
        end
        return {c[GROUP], c[GROUP-1], s};
    endfunction

    // Subtract preprocessing, group 0 from the inputs, group k from stage k-1
    always_comb begin
        w_b_pre       = bus.in_sub ? ~bus.in_b : bus.in_b;
        w_c0          = bus.in_sub | bus.in_cin;

        w_res         = cla_group(bus.in_a[GROUP-1:0], w_b_pre[GROUP-1:0], w_c0);
        w_nxt_vld[0]  = bus.in_valid;
        w_nxt_a[0]    = bus.in_a;
        w_nxt_b[0]    = w_b_pre;
        w_nxt_sum[0]  = '0;
        w_nxt_sum[0][GROUP-1:0] = w_res[GROUP-1:0];
        w_nxt_cmsb[0] = w_res[GROUP];
        w_nxt_c[0]    = w_res[GROUP+1];

        for (int k = 1; k < L; k++) begin
            w_res         = cla_group(r_a[k-1][k*GROUP +: GROUP],
                                      r_b[k-1][k*GROUP +: GROUP], r_c[k-1]);
            w_nxt_vld[k]  = r_vld[k-1];
            w_nxt_a[k]    = r_a[k-1];
            w_nxt_b[k]    = r_b[k-1];
            w_nxt_sum[k]  = r_sum[k-1];
            w_nxt_sum[k][k*GROUP +: GROUP] = w_res[GROUP-1:0];
            w_nxt_cmsb[k] = w_res[GROUP];
            w_nxt_c[k]    = w_res[GROUP+1];
        end
    end

    // Ready chain, flattened: stage k may advance unless it and every later
    // stage hold data while the output is blocked
    for (genvar k = 0; k < L; k++) begin : g_adv
        assign w_adv[k] = bus.out_ready | ~(&r_vld[L-1:k]);
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_vld[L-1];
    assign bus.out_sum   = r_sum[L-1];
    assign bus.out_cout  = r_c[L-1];
    assign bus.out_ovf   = r_c[L-1] ^ r_cmsb[L-1];

    // Each stage loads from its predecessor when it advances and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_c    <= '0;
            r_cmsb <= '0;
            for (int k = 0; k < L; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                if (w_adv[k]) begin
                    r_vld[k]  <= w_nxt_vld[k];
                    r_a[k]    <= w_nxt_a[k];
                    r_b[k]    <= w_nxt_b[k];
                    r_sum[k]  <= w_nxt_sum[k];
                    r_c[k]    <= w_nxt_c[k];
                    r_cmsb[k] <= w_nxt_cmsb[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder: a 16-bit/4-group instance (L=4) and an
// 8-bit/8-group instance (L=1), directed vectors with hand-computed results.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    pipelined_cla_adder_if #(.WIDTH(16)) bus16();
    pipelined_cla_adder_if #(.WIDTH(8))  bus8();

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Single transaction with out_ready=1: checks acceptance, the 4-edge latency
    // and the one-cycle result pulse. Starts and ends just after a rising edge.
    task automatic send_and_check(input vec_t v);
        bus16.in_valid = 1'b1;
        bus16.in_a     = v.a;
        bus16.in_b     = v.b;
        bus16.in_cin   = v.cin;
        bus16.in_sub   = v.sub;
        #1;
        chk("vec_in_ready", bus16.in_ready, 1);
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin
            chk("vec_latency_vld", bus16.out_valid, 0);
            @(posedge clk); #1;
        end
        chk("vec_vld",  bus16.out_valid, 1);
        chk("vec_sum",  bus16.out_sum,  v.sum);
        chk("vec_cout", bus16.out_cout, v.cout);
        chk("vec_ovf",  bus16.out_ovf,  v.ovf);
        @(posedge clk); #1;
        chk("vec_pulse_end", bus16.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   idx, oidx, occ;
        logic stalled, saw_full, acc, cons;
        logic [15:0] held_sum;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFE, 16'h0000, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

        bus16.in_valid = 0; bus16.in_a = 0; bus16.in_b = 0;
        bus16.in_cin = 0; bus16.in_sub = 0; bus16.out_ready = 1;
        bus8.in_valid = 0; bus8.in_a = 0; bus8.in_b = 0;
        bus8.in_cin = 0; bus8.in_sub = 0; bus8.out_ready = 1;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld",  bus16.out_valid, 0);
        chk("rst_sum",  bus16.out_sum,   0);
        chk("rst_cout", bus16.out_cout,  0);
        chk("rst_ovf",  bus16.out_ovf,   0);
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", bus16.in_ready, 1);

        // Directed vector table
        for (int i = 0; i < 8; i++) send_and_check(vecs[i]);

        // Backpressure: 8 back-to-back adds, out_ready low on cycles 5..9
        idx = 0; oidx = 0; stalled = 0; saw_full = 0; held_sum = '0;
        for (int cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
            bus16.out_ready = !(cyc >= 5 && cyc <= 9);
            bus16.in_valid  = (idx < 8);
            bus16.in_a      = 16'(idx);
            bus16.in_b      = 16'(idx * 32'h1111);
            bus16.in_cin    = 0;
            bus16.in_sub    = 0;
            #1;
            occ = idx - oidx;
            chk("bp_in_ready", bus16.in_ready, !(occ == 4 && !bus16.out_ready));
            if (!bus16.in_ready) saw_full = 1;
            if (stalled) begin
                chk("bp_stall_vld", bus16.out_valid, 1);
                chk("bp_stall_sum", bus16.out_sum, held_sum);
            end
            if (bus16.out_valid && bus16.out_ready) begin
                chk("bp_sum",  bus16.out_sum, 16'(oidx * 32'h1112));
                chk("bp_cout", bus16.out_cout, 0);
                chk("bp_ovf",  bus16.out_ovf,  0);
            end
            stalled  = bus16.out_valid & !bus16.out_ready;
            held_sum = bus16.out_sum;
            acc      = bus16.in_valid & bus16.in_ready;
            cons     = bus16.out_valid & bus16.out_ready;
            @(posedge clk); #1;
            idx  += int'(acc);
            oidx += int'(cons);
        end
        bus16.in_valid  = 0;
        bus16.out_ready = 1;
        chk("bp_count", oidx, 8);
        chk("bp_saw_full", saw_full, 1);
        @(posedge clk); #1;

        // Reset with three operations in flight, the oldest one on the output
        for (int i = 0; i < 3; i++) begin
            bus16.in_valid = 1;
            bus16.in_a     = 16'((i + 1) << 12);
            bus16.in_b     = 16'h0111;
            bus16.in_cin   = 0;
            bus16.in_sub   = 0;
            @(posedge clk); #1;
        end
        bus16.in_valid = 0;
        @(posedge clk); #1;
        chk("mid_pre_vld", bus16.out_valid, 1);
        chk("mid_pre_sum", bus16.out_sum, 16'h1111);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", bus16.out_valid, 0);
        chk("mid_rst_sum", bus16.out_sum, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            chk("mid_no_stale", bus16.out_valid, 0);
        end
        send_and_check(vecs[7]);

        // L=1 instance: result visible right after the accepting edge
        bus8.in_valid = 1; bus8.in_a = 8'hAA; bus8.in_b = 8'h55;
        bus8.in_cin = 1; bus8.in_sub = 0;
        #1;
        chk("l1_in_ready", bus8.in_ready, 1);
        chk("l1_pre_vld", bus8.out_valid, 0);
        @(posedge clk); #1;
        chk("l1_vld",  bus8.out_valid, 1);
        chk("l1_sum",  bus8.out_sum,   8'h00);
        chk("l1_cout", bus8.out_cout,  1);
        chk("l1_ovf",  bus8.out_ovf,   0);
        bus8.in_a = 8'h7F; bus8.in_b = 8'h01; bus8.in_cin = 0;
        @(posedge clk); #1;
        chk("l1b_vld",  bus8.out_valid, 1);
        chk("l1b_sum",  bus8.out_sum,   8'h80);
        chk("l1b_cout", bus8.out_cout,  0);
        chk("l1b_ovf",  bus8.out_ovf,   1);
        bus8.in_valid = 0;
        @(posedge clk); #1;
        chk("l1_end_vld", bus8.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
